clk_gen_multi: RTL
==================

Name: clk_gen_multi

Overview:
- Parametrised successor to the single fixed 1 kHz clock divider.
- Derives NUM_CH independent divided clocks from one board clock, each with a runtime-programmable half-period and a per-channel enable.
- Each channel also produces a one-cycle tick strobe.
- Sits at the top level between the board clock and the CPU and peripherals (CPU clock, LED scan, debounce). Ratio and enable changes take effect only at half-period boundaries, so every output clock is glitch-free.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_WIDTH, 32, width of the half-period value and channel counter.
- DEFAULT_HALF, 50000, half-period in clk cycles loaded at reset; 100 MHz gives 1 kHz.
- CH_W, $clog2(NUM_CH) (min 1), derived localparam; channel-select width.

Ports:
- clk  in  1  board clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  NUM_CH  per-channel run enable, level-sensitive.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted this cycle.
- cfg_ch  in  CH_W  target channel of the configuration.
- cfg_half  in  DIV_WIDTH  new half-period in clk cycles.
- clk_out  out  NUM_CH  divided clocks, 50% duty, registered.
- tick  out  NUM_CH  one-cycle pulse, high in the first cycle clk_out[i] is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, clk_out=0, tick=0.
  - half=DEFAULT_HALF for every channel.
  - pending=0, so cfg_ready=1.
  - Reset mid-operation drops clk_out to 0 immediately; this is the only permitted short pulse.
- Per-channel state: cnt, half, clk_out, pending flag, pend_half.
- Running (en[i]=1, or clk_out[i]=1):
  - Boundary when cnt==half-1: cnt<=0, clk_out toggles.
  - Otherwise cnt<=cnt+1.
  - Output period is 2*half cycles. Rising edge occurs half cycles after the channel leaves idle.
- Disable:
  - en[i]=0 while clk_out=1: the channel finishes the high half-period, toggles low, then idles.
  - Idle means cnt held at 0 and clk_out=0.
  - en[i]=0 while clk_out=0: the channel idles at once with cnt reset to 0. It never shortens a high phase.
- Re-enable from idle: counting restarts at 0 in the low phase.
- tick[i]: registered; equals 1 exactly in the cycle clk_out[i] transitions 0->1, otherwise 0.
- cfg handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - Accept on cfg_valid && cfg_ready, which sets pending[cfg_ch] and captures pend_half.
  - cfg_half=0 is stored as 1, giving divide-by-2.
  - Out-of-range cfg_ch (>=NUM_CH): cfg_ready=1, accepted, no effect.
- Apply:
  - Pending value loads into half at the next boundary (the same cycle cnt resets), and pending clears.
  - If the channel is idle, it applies on the next clk edge.
  - The new value governs the next half-period. The current half-period always completes with the old value.
- Simultaneous events:
  - Accept and boundary in the same cycle: the new value is not applied until the following boundary.
  - Configuring a channel with pending set stalls (cfg_ready=0) until that channel applies.
- Width: cnt is DIV_WIDTH bits, compared against half-1. No wrap is possible because half>=1.

Decomposition:
- Shared package (clk_gen_pkg):
  - DEFAULT_HALF presets (HALF_1KHZ=50000, HALF_1HZ=50000000 at 100 MHz).
  - SYSCLK_HZ constant.
- Sub-module clk_div_channel: one channel holding cnt, half, pending, clk_out and tick. It is instantiated NUM_CH times with generate.
- Top-level clk_gen_multi: cfg decode and the cfg_ready mux.

Test Plan:
- Reset values: NUM_CH=2, DEFAULT_HALF=4, en=2'b11, release reset -> clk_out rises on the 4th edge after release, period 8 cycles, tick high 1 cycle per period, cfg_ready=1 throughout.
- Mid-period reconfig: at cnt=1 of a low phase, write ch0 half=2 -> the current low phase stays 4 cycles, then high=2, low=2; cfg_ready for ch0 is 0 until the boundary; ch1 is unaffected.
- Back-to-back config: second cfg_valid to ch0 while pending -> cfg_ready=0 and the request is held; it is accepted the cycle after the boundary. cfg_half=0 -> period 2, tick every 2 cycles.
- Disable during high phase: drop en[0] 1 cycle after clk_out rises -> high lasts the full 4 cycles, then clk_out stays 0 and tick stays 0. Re-enable -> first rise 4 cycles later.
- Idle reconfig: channel disabled, write half=3 -> applied next edge; enable -> period 6.
- Async reset mid-high: assert reset between edges -> clk_out, tick and cnt go to 0 immediately; half reverts to 4 and pending clears.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared constants for the multi-channel clock generator: board clock rate
// and common half-period presets expressed in board clock cycles.
package clk_gen_pkg;

  localparam int SYSCLK_HZ = 100_000_000;

  // Half-period = SYSCLK_HZ / (2 * f_out)
  localparam int HALF_1KHZ = SYSCLK_HZ / 2_000;
  localparam int HALF_1HZ  = SYSCLK_HZ / 2;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counts board clocks, toggles its output at each
// half-period boundary and emits a tick on every rising output edge.
// A new half-period is held pending and only loaded at a boundary
// (or immediately while idle), so the output never glitches.
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_WIDTH    = 32,
  parameter int DEFAULT_HALF = HALF_1KHZ
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_half,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 pending
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] half;
  logic [DIV_WIDTH-1:0] pend_half;
  logic                 running;
  logic                 boundary;

  // A zero half-period would never reach a boundary; treat it as divide-by-2.
  function automatic logic [DIV_WIDTH-1:0] clamp_half(input logic [DIV_WIDTH-1:0] v);
    return (v == '0) ? DIV_WIDTH'(1) : v;
  endfunction

  // Keep running while enabled, or until an in-progress high phase completes.
  assign running  = en | clk_out;
  assign boundary = running && (cnt == half - DIV_WIDTH'(1));

  // Counter, output phase, tick and pending-apply control.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      half    <= DIV_WIDTH'(DEFAULT_HALF);
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (running) begin
        if (boundary) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          if (pending) begin
            half    <= pend_half;
            pending <= 1'b0;
          end
        end else begin
          cnt <= cnt + DIV_WIDTH'(1);
        end
      end else begin
        cnt <= '0;
        if (pending) begin
          half    <= pend_half;
          pending <= 1'b0;
        end
      end
      // Load is only offered when nothing is pending, so it never races the clear above.
      if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Capture the requested half-period; only meaningful while pending is set.
  always_ff @(posedge clk) begin
    if (load) begin
      pend_half <= clamp_half(load_half);
    end
  end

endmodule

// File: rtl/clk_gen_multi.sv
// Multi-channel clock generator: NUM_CH independent glitch-free dividers
// with a shared configuration port. A channel with a pending update stalls
// further configuration of that channel; unknown channels are accepted and
// ignored.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIV_WIDTH    = 32,
  parameter int DEFAULT_HALF = HALF_1KHZ,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_half,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick
);

  logic [NUM_CH-1:0]      pending;
  logic [(1<<CH_W)-1:0]   pend_pad;
  logic                   accept;

  // Pad pending flags to the full select range so out-of-range channels read as ready.
  always_comb begin
    pend_pad             = '0;
    pend_pad[NUM_CH-1:0] = pending;
  end

  assign cfg_ready = ~pend_pad[cfg_ch];
  assign accept    = cfg_valid & cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .DIV_WIDTH    (DIV_WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en        (en[i]),
      .load      (accept && (cfg_ch == CH_W'(i))),
      .load_half (cfg_half),
      .clk_out   (clk_out[i]),
      .tick      (tick[i]),
      .pending   (pending[i])
    );
  end

endmodule
